// File: rtl/led7_pkg.sv
// Shared seven-segment pattern constants and the code-to-pattern decode.
// Patterns are active-high, bit 6 = segment a down to bit 0 = segment g.
package led7_pkg;

    localparam logic [6:0] SegDig0 = 7'b1111110;
    localparam logic [6:0] SegDig1 = 7'b0110000;
    localparam logic [6:0] SegDig2 = 7'b1101101;
    localparam logic [6:0] SegDig3 = 7'b1111001;
    localparam logic [6:0] SegDig4 = 7'b0110011;
    localparam logic [6:0] SegDig5 = 7'b1011011;
    localparam logic [6:0] SegDig6 = 7'b1011111;
    localparam logic [6:0] SegDig7 = 7'b1110000;
    localparam logic [6:0] SegDig8 = 7'b1111111;
    localparam logic [6:0] SegDig9 = 7'b1111011;
    localparam logic [6:0] SegLetC = 7'b1001110;
    localparam logic [6:0] SegLetE = 7'b1001111;

    // Codes A..D have no glyph of their own and show 'E' as an error marker.
    function automatic logic [6:0] seg_decode(input logic [3:0] code);
        logic [6:0] pat;
        case (code)
            4'h0:    pat = SegDig0;
            4'h1:    pat = SegDig1;
            4'h2:    pat = SegDig2;
            4'h3:    pat = SegDig3;
            4'h4:    pat = SegDig4;
            4'h5:    pat = SegDig5;
            4'h6:    pat = SegDig6;
            4'h7:    pat = SegDig7;
            4'h8:    pat = SegDig8;
            4'h9:    pat = SegDig9;
            4'hE:    pat = SegLetC;
            default: pat = SegLetE;
        endcase
        return pat;
    endfunction

endpackage

// File: rtl/led7_seg_lut.sv
// Combinational 4-bit code to active-high seven-segment pattern lookup.
module led7_seg_lut
    import led7_pkg::*;
(
    input  logic [3:0] code_i,
    output logic [6:0] seg_o
);

    assign seg_o = seg_decode(code_i);

endmodule

// File: rtl/led7_scan_driver.sv
// Multiplexed seven-segment scan driver with frame-synchronous display update,
// leading-zero blanking and a dead band at the start of every digit slot.
module led7_scan_driver
    import led7_pkg::*;
#(
    parameter int unsigned N_DIGITS   = 4,
    parameter int unsigned SCAN_DIV   = 1000,
    parameter int unsigned DEAD       = 2,
    parameter int unsigned ACTIVE_LOW = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    load,
    input  logic [4*N_DIGITS-1:0]   digits,
    input  logic [N_DIGITS-1:0]     dp_in,
    input  logic                    lz_blank,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [N_DIGITS-1:0]     an,
    output logic                    frame_done
);

    localparam int unsigned PresW = $clog2(SCAN_DIV);
    localparam int unsigned IdxW  = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

    localparam logic [PresW-1:0] PresLast = PresW'(SCAN_DIV - 1);
    localparam logic [PresW-1:0] DeadEnd  = PresW'(DEAD);
    localparam logic [IdxW-1:0]  IdxLast  = IdxW'(N_DIGITS - 1);
    localparam logic             Inv      = (ACTIVE_LOW != 0);

    logic [PresW-1:0]      presc_q, presc_d;
    logic [IdxW-1:0]       idx_q, idx_d;
    logic [4*N_DIGITS-1:0] disp_dig_q, disp_dig_d, pend_dig_q, pend_dig_d;
    logic [N_DIGITS-1:0]   disp_dp_q, disp_dp_d, pend_dp_q, pend_dp_d;
    logic                  disp_lz_q, disp_lz_d, pend_lz_q, pend_lz_d;
    logic [6:0]            seg_q, seg_d;
    logic                  dp_q, dp_d;
    logic [N_DIGITS-1:0]   an_q, an_d;
    logic                  fd_q;

    logic                  slot_end, wrap;
    logic [3:0]            nib;
    logic                  dp_sel, blank_sel, lit;
    logic [N_DIGITS-1:0]   blank_vec;
    logic                  upper_zero;
    logic [6:0]            lut_seg;

    led7_seg_lut u_lut (
        .code_i (nib),
        .seg_o  (lut_seg)
    );

    assign slot_end = (presc_q == PresLast);
    assign wrap     = en && slot_end && (idx_q == IdxLast);

    always_comb begin
        presc_d = '0;
        idx_d   = '0;
        if (en) begin
            if (slot_end) begin
                idx_d = (idx_q == IdxLast) ? '0 : idx_q + 1'b1;
            end else begin
                presc_d = presc_q + 1'b1;
                idx_d   = idx_q;
            end
        end
    end

    // A load in the wrap cycle bypasses pending so the new frame already uses it.
    always_comb begin
        pend_dig_d = load ? digits   : pend_dig_q;
        pend_dp_d  = load ? dp_in    : pend_dp_q;
        pend_lz_d  = load ? lz_blank : pend_lz_q;
        disp_dig_d = wrap ? pend_dig_d : disp_dig_q;
        disp_dp_d  = wrap ? pend_dp_d  : disp_dp_q;
        disp_lz_d  = wrap ? pend_lz_d  : disp_lz_q;
    end

    always_comb begin
        upper_zero = 1'b1;
        blank_vec  = '0;
        for (int i = N_DIGITS - 1; i >= 0; i--) begin
            upper_zero   = upper_zero && (disp_dig_q[4*i +: 4] == 4'h0);
            blank_vec[i] = disp_lz_q && upper_zero && (i != 0);
        end
        nib       = '0;
        dp_sel    = 1'b0;
        blank_sel = 1'b0;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (idx_q == IdxW'(i)) begin
                nib       = disp_dig_q[4*i +: 4];
                dp_sel    = disp_dp_q[i];
                blank_sel = blank_vec[i];
            end
        end
    end

    always_comb begin
        lit  = en && (presc_q >= DeadEnd) && !blank_sel;
        an_d = '0;
        for (int i = 0; i < N_DIGITS; i++) begin
            an_d[i] = lit && (idx_q == IdxW'(i));
        end
        seg_d = (lit ? lut_seg : 7'h00) ^ {7{Inv}};
        dp_d  = (lit && dp_sel) ^ Inv;
        an_d  = an_d ^ {N_DIGITS{Inv}};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q    <= '0;
            idx_q      <= '0;
            disp_dig_q <= '0;
            disp_dp_q  <= '0;
            disp_lz_q  <= 1'b0;
            pend_dig_q <= '0;
            pend_dp_q  <= '0;
            pend_lz_q  <= 1'b0;
            seg_q      <= {7{Inv}};
            dp_q       <= Inv;
            an_q       <= {N_DIGITS{Inv}};
            fd_q       <= 1'b0;
        end else begin
            presc_q    <= presc_d;
            idx_q      <= idx_d;
            disp_dig_q <= disp_dig_d;
            disp_dp_q  <= disp_dp_d;
            disp_lz_q  <= disp_lz_d;
            pend_dig_q <= pend_dig_d;
            pend_dp_q  <= pend_dp_d;
            pend_lz_q  <= pend_lz_d;
            seg_q      <= seg_d;
            dp_q       <= dp_d;
            an_q       <= an_d;
            fd_q       <= wrap;
        end
    end

    assign seg        = seg_q;
    assign dp         = dp_q;
    assign an         = an_q;
    assign frame_done = fd_q;

endmodule

// File: tb/tb_led7_scan_driver.sv
// Bench for led7_scan_driver: 4 digits, 8-cycle slots, 2 dead cycles, active-low.
module tb_led7_scan_driver;

    logic        clk = 1'b0;
    logic        rst, en, load, lz_blank;
    logic [15:0] digits;
    logic [3:0]  dp_in;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
    logic        frame_done;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [3:0] code;
        logic [6:0] seg_al;
    } vec_t;

    typedef struct {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
    } exp_t;

    vec_t tbl[16];
    exp_t sb[$];

    led7_scan_driver #(
        .N_DIGITS   (4),
        .SCAN_DIV   (8),
        .DEAD       (2),
        .ACTIVE_LOW (1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .load       (load),
        .digits     (digits),
        .dp_in      (dp_in),
        .lz_blank   (lz_blank),
        .seg        (seg),
        .dp         (dp),
        .an         (an),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic do_load(input logic [15:0] d, input logic [3:0] p, input logic lz);
        digits   = d;
        dp_in    = p;
        lz_blank = lz;
        load     = 1'b1;
        step();
        load     = 1'b0;
    endtask

    task automatic wait_fd();
        int n = 0;
        while (frame_done !== 1'b1 && n < 64) begin
            step();
            n++;
        end
        check("frame_done_timeout", 32'(frame_done === 1'b1), 32'd1);
    endtask

    // Expected lit digits of one frame, in scan order.
    task automatic push_frame(input logic [15:0] d, input logic [3:0] p, input logic lz);
        exp_t e;
        logic [15:0] upper;
        for (int i = 0; i < 4; i++) begin
            upper = d >> (4 * i);
            if (i == 0 || !lz || upper != 16'h0) begin
                e.an  = ~(4'b0001 << i);
                e.seg = tbl[d[4*i +: 4]].seg_al;
                e.dp  = ~p[i];
                sb.push_back(e);
            end
        end
    endtask

    // Called in a frame_done cycle; walks the next full frame.
    task automatic scan_frame(input int mid_step, input logic [15:0] mid_digits);
        logic [3:0] prev_an = 4'hF;
        int   act = 0;
        int   fd_cnt = 0;
        int   fd_at = 0;
        int   expected_n = sb.size();
        exp_t e;
        for (int s = 1; s <= 32; s++) begin
            if (s == mid_step) begin
                digits = mid_digits;
                load   = 1'b1;
            end
            step();
            load = 1'b0;
            if (frame_done === 1'b1) begin
                fd_cnt++;
                fd_at = s;
            end
            if (an !== 4'hF) act++;
            if (an !== 4'hF && prev_an === 4'hF) begin
                if (sb.size() == 0) begin
                    check("extra_digit_an", 32'(an), 32'hF);
                end else begin
                    e = sb.pop_front();
                    check("slot_an", 32'(an), 32'(e.an));
                    check("slot_seg", 32'(seg), 32'(e.seg));
                    check("slot_dp", 32'(dp), 32'(e.dp));
                end
            end
            prev_an = an;
        end
        check("frame_done_count", 32'(fd_cnt), 32'd1);
        check("frame_done_period", 32'(fd_at), 32'd32);
        check("lit_cycles", 32'(act), 32'(6 * expected_n));
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        sb.delete();
    endtask

    initial begin
        tbl[0]  = '{4'h0, 7'b0000001};
        tbl[1]  = '{4'h1, 7'b1001111};
        tbl[2]  = '{4'h2, 7'b0010010};
        tbl[3]  = '{4'h3, 7'b0000110};
        tbl[4]  = '{4'h4, 7'b1001100};
        tbl[5]  = '{4'h5, 7'b0100100};
        tbl[6]  = '{4'h6, 7'b0100000};
        tbl[7]  = '{4'h7, 7'b0001111};
        tbl[8]  = '{4'h8, 7'b0000000};
        tbl[9]  = '{4'h9, 7'b0000100};
        tbl[10] = '{4'hA, 7'b0110000};
        tbl[11] = '{4'hB, 7'b0110000};
        tbl[12] = '{4'hC, 7'b0110000};
        tbl[13] = '{4'hD, 7'b0110000};
        tbl[14] = '{4'hE, 7'b0110001};
        tbl[15] = '{4'hF, 7'b0110000};

        rst = 1'b1; en = 1'b0; load = 1'b0; lz_blank = 1'b0;
        digits = 16'h0; dp_in = 4'h0;
        step();
        step();
        check("rst_seg", 32'(seg), 32'h7F);
        check("rst_dp", 32'(dp), 32'd1);
        check("rst_an", 32'(an), 32'hF);
        check("rst_frame_done", 32'(frame_done), 32'd0);
        rst = 1'b0;

        // Basic scan with a decimal point on digit 1.
        en = 1'b1;
        do_load(16'h1234, 4'b0010, 1'b0);
        wait_fd();
        push_frame(16'h1234, 4'b0010, 1'b0);
        scan_frame(0, 16'h0);

        // Leading-zero suppression; dp on blanked digits must stay dark.
        do_load(16'h0070, 4'b1101, 1'b1);
        wait_fd();
        push_frame(16'h0070, 4'b1101, 1'b1);
        scan_frame(0, 16'h0);

        // Tear-free update: mid-frame load shows only from the next frame.
        do_load(16'h1111, 4'b0000, 1'b0);
        wait_fd();
        push_frame(16'h1111, 4'b0000, 1'b0);
        scan_frame(10, 16'h5555);
        push_frame(16'h5555, 4'b0000, 1'b0);
        scan_frame(0, 16'h0);

        // Decode table, four codes per frame.
        for (int g = 0; g < 4; g++) begin
            logic [15:0] d;
            d = {tbl[4*g+3].code, tbl[4*g+2].code, tbl[4*g+1].code, tbl[4*g].code};
            do_load(d, 4'b0000, 1'b0);
            wait_fd();
            push_frame(d, 4'b0000, 1'b0);
            scan_frame(0, 16'h0);
        end

        // Disable mid-frame, load while disabled, then re-enable.
        step();
        step();
        step();
        en = 1'b0;
        step();
        check("dis_an", 32'(an), 32'hF);
        check("dis_seg", 32'(seg), 32'h7F);
        check("dis_frame_done", 32'(frame_done), 32'd0);
        do_load(16'h0008, 4'b0000, 1'b0);
        step();
        check("dis_an_hold", 32'(an), 32'hF);
        en = 1'b1;
        step();
        check("en_dead0_an", 32'(an), 32'hF);
        step();
        check("en_dead1_an", 32'(an), 32'hF);
        step();
        check("en_first_an", 32'(an), 32'hE);
        wait_fd();
        push_frame(16'h0008, 4'b0000, 1'b0);
        scan_frame(0, 16'h0);

        // Reset at digit 2, slot cycle 5.
        for (int s = 0; s < 21; s++) step();
        check("pre_rst_an", 32'(an), 32'hB);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mid_rst_seg", 32'(seg), 32'h7F);
        check("mid_rst_dp", 32'(dp), 32'd1);
        check("mid_rst_an", 32'(an), 32'hF);
        check("mid_rst_frame_done", 32'(frame_done), 32'd0);
        step();
        check("post_rst_dead0_an", 32'(an), 32'hF);
        step();
        check("post_rst_dead1_an", 32'(an), 32'hF);
        step();
        check("post_rst_first_an", 32'(an), 32'hE);
        check("post_rst_first_seg", 32'(seg), 32'h01);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/led7_scan_driver.md
LED7_SCAN_DRIVER -- requirements
Module: led7_scan_driver

Interface
REQ-001 Parameter N_DIGITS, default 4: number of multiplexed digits, range 1..8.
REQ-002 Parameter SCAN_DIV, default 1000: clock cycles per digit slot, at least 4.
REQ-003 Parameter DEAD, default 2: anode-off cycles at the start of each slot, at least 1 and less than SCAN_DIV.
REQ-004 Parameter ACTIVE_LOW, default 1: when 1, seg, dp and an are driven active-low (common anode).
REQ-005 Port clk, input, 1 bit: the single clock, rising-edge.
REQ-006 Port rst, input, 1 bit: reset, synchronous and active-high.
REQ-007 Port en, input, 1 bit: display enable.
REQ-008 Port load, input, 1 bit: single-cycle strobe that captures digits, dp_in and lz_blank.
REQ-009 Port digits, input, 4*N_DIGITS bits: BCD/code nibbles; nibble 0 is least significant and rightmost.
REQ-010 Port dp_in, input, N_DIGITS bits: decimal point per digit.
REQ-011 Port lz_blank, input, 1 bit: leading-zero suppression enable.
REQ-012 Port seg, output, 7 bits: segments, seg[6]=a down to seg[0]=g.
REQ-013 Port dp, output, 1 bit: decimal-point segment.
REQ-014 Port an, output, N_DIGITS bits: digit select; an[i] drives digit i.
REQ-015 Port frame_done, output, 1 bit: one-cycle pulse at the end of each full scan.

Function
REQ-016 Decode shall use active-high patterns: 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011, 4'hE='C'=1001110, 4'hF='E'=1001111; codes 4'hA to 4'hD shall decode as 'E' (error).
REQ-017 When ACTIVE_LOW=1, the module shall invert seg, dp and an at the output registers.
REQ-018 A prescaler shall count 0..SCAN_DIV-1; on its terminal count, the digit index shall advance from 0 upward and wrap from N_DIGITS-1 to 0.
REQ-019 frame_done shall pulse during the cycle in which the index wraps from N_DIGITS-1 to 0.
REQ-020 load shall write a pending register; pending contents shall copy to the display register only at a wrap (frame boundary), so no frame mixes old and new values.
REQ-021 If load coincides with a wrap, the new value shall be used for the frame that starts at that wrap.
REQ-022 Repeated loads within one frame shall follow last-write-wins.
REQ-023 With lz_blank=1, digit i (i>0) shall be blanked when it and all higher nibbles are 4'h0; digit 0 shall never be blanked.
REQ-024 A blanked digit shall drive its anode inactive for the whole slot; its dp shall also be suppressed.
REQ-025 For prescaler values 0..DEAD-1, all anodes shall be inactive; from DEAD to SCAN_DIV-1, only an[index] shall be active.
REQ-026 seg, dp and an shall be registered, reflecting the prescaler/index state of the previous cycle (1-cycle latency).
REQ-027 When en=0, outputs shall be inactive and the prescaler and index shall be held at 0; scanning shall start at digit 0 one cycle after en rises.
REQ-028 The pending register shall accept load regardless of the state of en.

Reset
REQ-029 On rst, the prescaler, index, display register and pending register shall all clear to 0.
REQ-030 On rst, seg, dp and an shall go inactive (all 1 when ACTIVE_LOW=1) and frame_done shall be 0, all on the next clock edge.
REQ-031 rst shall take priority over en and load; scanning after reset shall begin at digit 0, slot cycle 0.

Structure
REQ-032 Package led7_pkg shall hold the twelve segment pattern constants and the code-to-pattern decode function.
REQ-033 Sub-module led7_seg_lut (combinational, 4-bit code to 7-bit active-high pattern) shall be instantiated once, on the muxed nibble.

Verification
REQ-034 The bench shall use N_DIGITS=4, SCAN_DIV=8, DEAD=2 and ACTIVE_LOW=1 for all scenarios below.
REQ-035 Reset: assert rst for 2 cycles -> seg=7'h7F, dp=1, an=4'hF, frame_done=0.
REQ-036 Basic scan: load digits=16'h1234, en=1 -> digit-0 slot gives seg=7'b1001100 and an=4'b1110 from slot cycle 3; frame_done pulses every 32 cycles.
REQ-037 Leading-zero suppression: lz_blank=1, digits=16'h0070 -> an[3] and an[2] never active; digit 1 shows 7 (seg=7'b0001111); digit 0 shows 0 (seg=7'b0000001).
REQ-038 Tear-free load: load 16'h5555 mid-frame, while 16'h1111 is displayed -> rest of frame shows 1; 5 first appears at digit 0 after the next frame_done.
REQ-039 Error codes: nibble 4'hB -> seg=7'b0110000 ('E'); nibble 4'hE -> seg=7'b0110001 ('C').
REQ-040 Reset mid-scan: rst at digit 2, slot cycle 5 -> next cycle all outputs inactive; after release, digit 0 becomes active DEAD+1 cycles later.
